// File: rtl/oled_bus_writer_if.sv
// Host-side handshake bundle for oled_bus_writer: a command stage
// (cmd_valid/cmd_ready with cmd and len) and a data stage (data_valid/data_ready with data).
// The master modport is the host that issues commands. The slave modport is the bus writer.
interface oled_bus_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd;
  logic [LEN_W-1:0]      len;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output cmd_valid, cmd, len, data_valid, data,
    input  cmd_ready, data_ready
  );

  modport slave (
    input  cmd_valid, cmd, len, data_valid, data,
    output cmd_ready, data_ready
  );
endinterface

// File: rtl/oled_bus_writer.sv
// oled_bus_writer: write-only controller for a 6800-style OLED parallel bus.
// Each frame is one command byte followed by 0..MAX_LEN data bytes.
// For every byte the controller runs this sequence:
//   SETUP  : E low, q stable, for one clock.
//   STROBE : E high for E_CYCLES clocks.
//   HOLD   : E low for GAP_CYCLES clocks. The panel latches the byte on this falling edge of E.
// Compile-time option OLED_INIT_EN:
//   - A power-on init sequence is replayed from a ROM image (INIT_DATA) as one frame.
//   - Host commands are not accepted until that frame has finished.
//   - Without OLED_INIT_EN, init_done is a constant 1.
//   - Without OLED_INIT_EN, the controller is idle immediately after reset.
module oled_bus_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int E_CYCLES   = 2,
  parameter int GAP_CYCLES = 1,
  parameter int INIT_DEPTH = 64,
  parameter     INIT_FILE  = "OLED.hex",
  parameter logic [INIT_DEPTH*(DATA_WIDTH+1)-1:0] INIT_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  oled_bus_writer_if.slave      host,
  output logic                  busy,
  output logic                  init_done,
  output logic                  oled_cs,
  output logic                  oled_e,
  output logic                  oled_rw,
  output logic                  oled_dc,
  output logic [DATA_WIDTH-1:0] oled_q
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int CNT_MX = (E_CYCLES > GAP_CYCLES) ? E_CYCLES : GAP_CYCLES;
  localparam int CNT_W  = (CNT_MX > 1) ? $clog2(CNT_MX) : 1;

  if (E_CYCLES < 1 || GAP_CYCLES < 1 || INIT_DEPTH < 1) begin : g_param_check
    $error("oled_bus_writer: E_CYCLES, GAP_CYCLES and INIT_DEPTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_FETCH,
    S_DONE
  } state_t;

`ifdef OLED_INIT_EN
  localparam state_t RESET_STATE = S_INIT;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t                state_q;
  logic [LEN_W-1:0]      rem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  cs_q;
  logic                  e_q;
  logic                  dc_q;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  init_done_w;
  logic                  cmd_ready_w;
  logic [LEN_W-1:0]      len_d;

`ifdef OLED_INIT_EN
  localparam int AW  = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
  localparam int ACW = $clog2(INIT_DEPTH + 1);

  logic [DATA_WIDTH:0] rom_dout_q;
  logic [ACW-1:0]      rom_addr_q;
  logic                rom_phase_q;
  logic                init_done_q;

  // Synchronous ROM read: the word at rom_addr_q is available one clock later.
  always_ff @(posedge clk) begin
    if (rom_addr_q < ACW'(INIT_DEPTH)) begin
      rom_dout_q <= INIT_DATA[int'(rom_addr_q[AW-1:0]) * (DATA_WIDTH + 1) +: (DATA_WIDTH + 1)];
    end
  end

  assign init_done_w = init_done_q;
`else
  assign init_done_w = 1'b1;
`endif

  // Requests longer than the frame buffer are truncated, not rejected.
  always_comb begin
    len_d = host.len;
    if (host.len > LEN_W'(MAX_LEN)) begin
      len_d = LEN_W'(MAX_LEN);
    end
  end

  // Handshake readiness and busy are decoded straight from the state.
  assign cmd_ready_w     = (state_q == S_IDLE) && init_done_w;
  assign host.cmd_ready  = cmd_ready_w;
  assign host.data_ready = (state_q == S_FETCH);
  assign busy            = (state_q != S_IDLE);
  assign init_done       = init_done_w;

  assign oled_cs = cs_q;
  assign oled_e  = e_q;
  assign oled_rw = 1'b0;
  assign oled_dc = dc_q;
  assign oled_q  = q_q;

  // Bus sequencer. Each pin value is registered on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      rem_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      e_q     <= 1'b0;
      dc_q    <= 1'b0;
      q_q     <= '0;
`ifdef OLED_INIT_EN
      rom_addr_q  <= '0;
      rom_phase_q <= 1'b0;
      init_done_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
`ifdef OLED_INIT_EN
        // First clock lets the ROM word settle. The second clock loads it onto the bus.
        // cs is held low across all init entries, so they form a single frame.
        S_INIT: begin
          if (!rom_phase_q) begin
            rom_phase_q <= 1'b1;
          end else begin
            rom_phase_q <= 1'b0;
            q_q         <= rom_dout_q[DATA_WIDTH-1:0];
            dc_q        <= rom_dout_q[DATA_WIDTH];
            cs_q        <= 1'b0;
            rom_addr_q  <= rom_addr_q + ACW'(1);
            state_q     <= S_SETUP;
          end
        end
`endif
        S_IDLE: begin
          if (host.cmd_valid && cmd_ready_w) begin
            q_q     <= host.cmd;
            dc_q    <= 1'b0;
            cs_q    <= 1'b0;
            rem_q   <= len_d;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          e_q     <= 1'b1;
          cnt_q   <= CNT_W'(E_CYCLES - 1);
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            e_q     <= 1'b0;
            cnt_q   <= CNT_W'(GAP_CYCLES - 1);
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
`ifdef OLED_INIT_EN
          end else if (!init_done_q) begin
            if (rom_addr_q == ACW'(INIT_DEPTH)) begin
              cs_q    <= 1'b1;
              dc_q    <= 1'b0;
              state_q <= S_DONE;
            end else begin
              state_q <= S_INIT;
            end
`endif
          end else if (rem_q != '0) begin
            state_q <= S_FETCH;
          end else begin
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            state_q <= S_DONE;
          end
        end
        // Stalls here with cs low and the last byte still on q until the host supplies data.
        S_FETCH: begin
          if (host.data_valid) begin
            q_q     <= host.data;
            dc_q    <= 1'b1;
            rem_q   <= rem_q - LEN_W'(1);
            state_q <= S_SETUP;
          end
        end
        S_DONE: begin
`ifdef OLED_INIT_EN
          init_done_q <= 1'b1;
`endif
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_bus_writer.sv
// Directed bench for oled_bus_writer.
// The bench drives inputs and checks outputs 1 ns after each rising edge.
// A monitor on the falling clock edge records two things:
//   - every 1->0 transition of oled_e, together with its (dc, q) pair
//   - every data handshake
// With OLED_INIT_EN, the DUT is built with INIT_DEPTH=4 and the ROM image 0AE 0A0 151 0AF.
module tb_oled_bus_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, init_done, oled_cs, oled_e, oled_rw, oled_dc;
  logic [7:0] oled_q;

  oled_bus_writer_if #(.DATA_WIDTH(8), .MAX_LEN(16)) bus ();

  oled_bus_writer #(
    .DATA_WIDTH(8), .MAX_LEN(16), .E_CYCLES(2), .GAP_CYCLES(1),
    .INIT_DEPTH(4), .INIT_FILE("OLED.hex"),
    .INIT_DATA({9'h0AF, 9'h151, 9'h0A0, 9'h0AE})
  ) dut (
    .clk(clk), .rst(rst), .host(bus), .busy(busy), .init_done(init_done),
    .oled_cs(oled_cs), .oled_e(oled_e), .oled_rw(oled_rw), .oled_dc(oled_dc),
    .oled_q(oled_q)
  );

  always #5 clk = ~clk;

`ifdef OLED_INIT_EN
  localparam logic BUSY_IN_RESET = 1'b1;
`else
  localparam logic BUSY_IN_RESET = 1'b0;
`endif

  int         n_chk = 0;
  int         n_err = 0;
  logic [8:0] falls [$];
  int         hs_cnt = 0;
  logic       e_prev = 1'b0;
  logic [7:0] dbytes [0:31];
  int         stall_cnt;
  int         stall_bad;

  // Records falling E edges and data handshakes, away from the DUT's active edge.
  always @(negedge clk) begin
    if (e_prev && !oled_e) falls.push_back({oled_dc, oled_q});
    if (bus.data_valid && bus.data_ready && !rst) hs_cnt <= hs_cnt + 1;
    e_prev <= oled_e;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one frame and feeds dbytes[0..nbytes-1] whenever the DUT asks for data.
  // Data is withheld for stall_len FETCH clocks before byte stall_idx.
  // Returns the number of clocks from the command handshake until cmd_ready is high again.
  task automatic run_frame(input logic [7:0] c, input logic [4:0] l, input int nbytes,
                           input int stall_idx, input int stall_len, output int frame_cyc);
    int idx;
    int k;
    int hs0;
    idx = 0;
    hs0 = hs_cnt;
    stall_cnt = 0;
    stall_bad = 0;
    bus.cmd = c;
    bus.len = l;
    bus.cmd_valid = 1'b1;
    bus.data = dbytes[0];
    bus.data_valid = (nbytes > 0) && (stall_idx != 0);
    tick();
    bus.cmd_valid = 1'b0;
    k = 1;
    while (!bus.cmd_ready && k < 400) begin
      if (hs_cnt - hs0 > idx) begin
        idx = hs_cnt - hs0;
        bus.data = dbytes[idx];
        bus.data_valid = (idx < nbytes) && (idx != stall_idx);
      end
      if (idx == stall_idx && !bus.data_valid && bus.data_ready) begin
        stall_cnt++;
        if (oled_cs !== 1'b0 || oled_e !== 1'b0 || oled_dc !== 1'b1 || oled_q !== dbytes[idx-1])
          stall_bad++;
        if (stall_cnt >= stall_len) bus.data_valid = (idx < nbytes);
      end
      tick();
      k++;
    end
    bus.data_valid = 1'b0;
    frame_cyc = k;
  endtask

  initial begin
    int f0;
    int h0;
    int fc;
    int k;
    int bad;
    bus.cmd_valid = 1'b0;
    bus.cmd = '0;
    bus.len = '0;
    bus.data_valid = 1'b0;
    bus.data = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_cs", oled_cs, 1);
    chk("rst_e", oled_e, 0);
    chk("rst_rw", oled_rw, 0);
    chk("rst_dc", oled_dc, 0);
    chk("rst_q", oled_q, 8'h00);
    chk("rst_busy", busy, BUSY_IN_RESET);
    rst = 1'b0;

`ifdef OLED_INIT_EN
    // Init replay
    f0 = falls.size();
    bad = 0;
    k = 0;
    chk("init_done_low", init_done, 0);
    while (!init_done && k < 300) begin
      if (bus.cmd_ready) bad++;
      tick();
      k++;
    end
    chk("init_done_rise", init_done, 1);
    chk("init_rdy_early", bad, 0);
    chk("init_nfalls", falls.size() - f0, 4);
    chk("init_f0", falls[f0],   9'h0AE);
    chk("init_f1", falls[f0+1], 9'h0A0);
    chk("init_f2", falls[f0+2], 9'h151);
    chk("init_f3", falls[f0+3], 9'h0AF);
    chk("init_cs_high", oled_cs, 1);
`else
    tick();
`endif
    chk("idle_rdy", bus.cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_init_done", init_done, 1);

    // Command only: 0xAF, len 0
    f0 = falls.size();
    bus.cmd = 8'hAF;
    bus.len = 5'd0;
    bus.cmd_valid = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      bus.cmd_valid = 1'b0;
      chk($sformatf("co_cs_%0d", e), oled_cs, (e <= 4) ? 1'b0 : 1'b1);
      chk($sformatf("co_e_%0d", e), oled_e, (e == 2 || e == 3) ? 1'b1 : 1'b0);
      chk($sformatf("co_rdy_%0d", e), bus.cmd_ready, (e == 6) ? 1'b1 : 1'b0);
      if (e == 1) chk("co_q", oled_q, 8'hAF);
      if (e == 2) chk("co_dc", oled_dc, 0);
    end
    chk("co_nfalls", falls.size() - f0, 1);
    chk("co_fall", falls[f0], 9'h0AF);

    // Command 0x15 with two back-to-back data bytes
    dbytes[0] = 8'h00;
    dbytes[1] = 8'h7F;
    f0 = falls.size();
    h0 = hs_cnt;
    run_frame(8'h15, 5'd2, 2, -1, 0, fc);
    chk("b2b_cycles", fc, 16);
    chk("b2b_hs", hs_cnt - h0, 2);
    chk("b2b_nfalls", falls.size() - f0, 3);
    chk("b2b_f0", falls[f0],   9'h015);
    chk("b2b_f1", falls[f0+1], 9'h100);
    chk("b2b_f2", falls[f0+2], 9'h17F);

    // Host stalls for 10 FETCH clocks before the second data byte
    dbytes[0] = 8'h11;
    dbytes[1] = 8'h22;
    f0 = falls.size();
    h0 = hs_cnt;
    run_frame(8'h3C, 5'd2, 2, 1, 10, fc);
    chk("stall_len", stall_cnt, 10);
    chk("stall_hold", stall_bad, 0);
    chk("stall_cycles", fc, 25);
    chk("stall_hs", hs_cnt - h0, 2);
    chk("stall_nfalls", falls.size() - f0, 3);
    chk("stall_f2", falls[f0+2], 9'h122);

    // len = MAX_LEN+3 is clamped to MAX_LEN
    for (int i = 0; i < 32; i++) dbytes[i] = 8'h40 + 8'(i);
    f0 = falls.size();
    h0 = hs_cnt;
    run_frame(8'hB3, 5'd19, 19, -1, 0, fc);
    chk("clamp_hs", hs_cnt - h0, 16);
    chk("clamp_nfalls", falls.size() - f0, 17);
    chk("clamp_last", falls[f0+16], 9'h14F);
    chk("clamp_cycles", fc, 86);

    // Reset asserted during the strobe of the first data byte
    h0 = hs_cnt;
    bus.cmd = 8'h5A;
    bus.len = 5'd2;
    bus.cmd_valid = 1'b1;
    bus.data = 8'hA1;
    bus.data_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!(oled_e && oled_dc) && k < 50) begin
      tick();
      k++;
      if (hs_cnt - h0 > 0) bus.data = 8'hA2;
    end
    chk("mid_reach", oled_e && oled_dc, 1);
    chk("mid_q", oled_q, 8'hA1);
    rst = 1'b1;
    tick();
    chk("mid_cs", oled_cs, 1);
    chk("mid_e", oled_e, 0);
    chk("mid_q0", oled_q, 8'h00);
    chk("mid_dc", oled_dc, 0);
    rst = 1'b0;
    tick();
    f0 = falls.size();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.data_ready) bad++;
      tick();
    end
    chk("mid_no_dready", bad, 0);
    chk("mid_hs", hs_cnt - h0, 1);
    chk("mid_no_falls", falls.size() - f0, 0);
    bus.data_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
